// File: rtl/mem_stage.sv
// mem_stage: memory stage of the mini-core pipeline.
// Executes loads/stores over a req/ack memory handshake, produces the
// register-file writeback and latches the halt condition.
// Optional feature macro: MEM_TIMEOUT_EN (per-access watchdog, sticky mem_err).
//
// Handshake: mem_req is raised together with mem_we/mem_addr/mem_wdata and all
// four stay stable until mem_ack is sampled high on a rising edge; mem_ack is a
// one-cycle strobe and is only honoured while an access is outstanding.
module mem_stage #(
  parameter int TO_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       halted,
  input  logic       data_rw,
  input  logic       data_mem_write,
  input  logic [7:0] alu_output,
  input  logic [5:0] write_addr,
  output logic       mem_req,
  output logic       mem_we,
  output logic [5:0] mem_addr,
  output logic [7:0] mem_wdata,
  input  logic [7:0] mem_rdata,
  input  logic       mem_ack,
  output logic       freeze,
  output logic       wb_en,
  output logic [5:0] wb_addr,
  output logic [7:0] wb_data,
  output logic       halted_out,
  output logic       mem_err
);

  // Reject a watchdog limit that could never expire.
  if (TO_CYCLES < 1) begin : g_bad_to_cycles
    $error("mem_stage: TO_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    HALT   = 2'd2
  } state_t;

  // Current FSM state; kept as a named signal so checkers can bind to it.
  state_t     state, state_d;

  logic       mem_req_d, mem_we_d;
  logic [5:0] mem_addr_d;
  logic [7:0] mem_wdata_d;
  logic       wb_en_d;
  logic [5:0] wb_addr_d;
  logic [7:0] wb_data_d;
  logic       halted_d;
  logic [5:0] dest, dest_d;   // load destination register

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TO_CYCLES + 1);
  logic [CNT_W-1:0] to_cnt, to_cnt_d;
  logic             err_d;
  logic             timeout;

  // Limit edge: this is the TO_CYCLES-th edge spent in ACCESS.
  assign timeout = (to_cnt == CNT_W'(TO_CYCLES - 1));
`else
  assign mem_err = 1'b0;
`endif

  assign freeze = (state == ACCESS);

  // Next-state and next-output decode; everything holds unless changed below.
  always_comb begin
    state_d     = state;
    mem_req_d   = mem_req;
    mem_we_d    = mem_we;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    wb_en_d     = 1'b0;
    wb_addr_d   = wb_addr;
    wb_data_d   = wb_data;
    halted_d    = halted_out;
    dest_d      = dest;
`ifdef MEM_TIMEOUT_EN
    to_cnt_d    = to_cnt + 1'b1;
    err_d       = mem_err;
`endif
    case (state)
      IDLE: begin
`ifdef MEM_TIMEOUT_EN
        to_cnt_d = '0;
`endif
        if (halted) begin
          state_d  = HALT;
          halted_d = 1'b1;
        end else if (data_mem_write) begin
          state_d     = ACCESS;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = write_addr;
          mem_wdata_d = alu_output;
        end else if (data_rw) begin
          state_d    = ACCESS;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = alu_output[5:0];
          dest_d     = write_addr;
        end else if (write_addr != 6'd0) begin
          wb_en_d   = 1'b1;
          wb_addr_d = write_addr;
          wb_data_d = alu_output;
        end
      end
      ACCESS: begin
        if (mem_ack) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          if (!mem_we && dest != 6'd0) begin
            wb_en_d   = 1'b1;
            wb_addr_d = dest;
            wb_data_d = mem_rdata;
          end
        end
`ifdef MEM_TIMEOUT_EN
        else if (timeout) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          err_d     = 1'b1;
          if (!mem_we && dest != 6'd0) begin
            wb_en_d   = 1'b1;
            wb_addr_d = dest;
            wb_data_d = 8'hFF;
          end
        end
`endif
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 6'd0;
      mem_wdata  <= 8'd0;
      wb_en      <= 1'b0;
      wb_addr    <= 6'd0;
      wb_data    <= 8'd0;
      halted_out <= 1'b0;
      dest       <= 6'd0;
`ifdef MEM_TIMEOUT_EN
      to_cnt     <= '0;
      mem_err    <= 1'b0;
`endif
    end else begin
      state      <= state_d;
      mem_req    <= mem_req_d;
      mem_we     <= mem_we_d;
      mem_addr   <= mem_addr_d;
      mem_wdata  <= mem_wdata_d;
      wb_en      <= wb_en_d;
      wb_addr    <= wb_addr_d;
      wb_data    <= wb_data_d;
      halted_out <= halted_d;
      dest       <= dest_d;
`ifdef MEM_TIMEOUT_EN
      to_cnt     <= to_cnt_d;
      mem_err    <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: randomized self-checking bench for mem_stage.
// A memory device model answers requests; a reference model derives every
// expected writeback and memory request from the instruction semantics.
module tb_mem_stage;

  localparam int TO = 4;
`ifdef MEM_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       halted = 1'b0;
  logic       data_rw = 1'b0;
  logic       data_mem_write = 1'b0;
  logic [7:0] alu_output = 8'd0;
  logic [5:0] write_addr = 6'd0;
  logic [7:0] mem_rdata = 8'd0;
  logic       mem_ack = 1'b0;
  logic       mem_req, mem_we, freeze, wb_en, halted_out, mem_err;
  logic [5:0] mem_addr, wb_addr;
  logic [7:0] mem_wdata, wb_data;

  always #5 clk = ~clk;

  mem_stage #(.TO_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .halted(halted), .data_rw(data_rw),
    .data_mem_write(data_mem_write), .alu_output(alu_output),
    .write_addr(write_addr), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .freeze(freeze), .wb_en(wb_en), .wb_addr(wb_addr),
    .wb_data(wb_data), .halted_out(halted_out), .mem_err(mem_err)
  );

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_errors = 0;
  logic [13:0] exp_q[$];          // expected writebacks {addr, data}
  logic [7:0]  ref_mem[64];       // reference model memory
  logic [7:0]  dev_mem[64];       // memory device seen by the DUT
  bit          halt_seen = 1'b0;
  bit          exp_err = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Memory device: commits a store when the request is acknowledged.
  always @(posedge clk) begin
    if (rst_n && mem_req && mem_ack && mem_we) dev_mem[mem_addr] = mem_wdata;
  end

  // Writeback monitor: every wb_en cycle must match the next expected entry.
  always @(negedge clk) begin
    if (rst_n && wb_en) begin
      if (exp_q.size() == 0) check_eq("wb_unexpected", wb_en, 1'b0);
      else check_eq("wb_addr_data", {wb_addr, wb_data}, exp_q.pop_front());
    end
  end

  // Bound on total run time.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  task automatic drive_nop();
    halted = 1'b0; data_rw = 1'b0; data_mem_write = 1'b0;
    alu_output = 8'd0; write_addr = 6'd0; mem_ack = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_mem_req"}, mem_req, 1'b0);
    check_eq({tag, "_mem_we"}, mem_we, 1'b0);
    check_eq({tag, "_mem_addr"}, mem_addr, 6'd0);
    check_eq({tag, "_mem_wdata"}, mem_wdata, 8'd0);
    check_eq({tag, "_freeze"}, freeze, 1'b0);
    check_eq({tag, "_wb_en"}, wb_en, 1'b0);
    check_eq({tag, "_wb_addr"}, wb_addr, 6'd0);
    check_eq({tag, "_wb_data"}, wb_data, 8'd0);
    check_eq({tag, "_halted_out"}, halted_out, 1'b0);
    check_eq({tag, "_mem_err"}, mem_err, 1'b0);
  endtask

  // Reset; returns just after a falling edge with rst_n released.
  task automatic apply_reset();
    rst_n = 1'b0;
    drive_nop();
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    halt_seen = 1'b0;
    exp_err = 1'b0;
    exp_q.delete();
  endtask

  // Present one instruction at a falling edge and follow it to completion.
  // k = edge count until ack; noack lets the watchdog expire instead.
  task automatic run_instr(input bit h, input bit rw, input bit mw,
                           input logic [7:0] alu, input logic [5:0] wa,
                           input int k, input bit noack);
    int         kind;     // 0 alu, 1 store, 2 load, 3 halt
    int         cycles;
    logic [5:0] exp_addr;
    kind = h ? 3 : (mw ? 1 : (rw ? 2 : 0));
    halted = h; data_rw = rw; data_mem_write = mw;
    alu_output = alu; write_addr = wa;
    mem_ack = (kind == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
    mem_rdata = 8'($urandom);
    if (kind == 0 && wa != 6'd0 && !halt_seen) exp_q.push_back({wa, alu});
    @(negedge clk);
    if (halt_seen) begin
      check_eq("halt_no_wb", wb_en, 1'b0);
      check_eq("halt_no_req", mem_req, 1'b0);
      check_eq("halt_no_freeze", freeze, 1'b0);
      check_eq("halt_sticky", halted_out, 1'b1);
      return;
    end
    check_eq("mem_err", mem_err, exp_err);
    case (kind)
      0: begin
        check_eq("alu_wb_en", wb_en, wa != 6'd0);
        check_eq("alu_no_req", mem_req, 1'b0);
        check_eq("alu_no_freeze", freeze, 1'b0);
      end
      3: begin
        check_eq("halt_out", halted_out, 1'b1);
        check_eq("halt_req", mem_req, 1'b0);
        check_eq("halt_wb_en", wb_en, 1'b0);
        check_eq("halt_freeze", freeze, 1'b0);
        halt_seen = 1'b1;
      end
      default: begin
        exp_addr = (kind == 1) ? wa : alu[5:0];
        check_eq("acc_req", mem_req, 1'b1);
        check_eq("acc_freeze", freeze, 1'b1);
        check_eq("acc_we", mem_we, kind == 1);
        check_eq("acc_addr", mem_addr, exp_addr);
        if (kind == 1) check_eq("acc_wdata", mem_wdata, alu);
        check_eq("acc_no_wb", wb_en, 1'b0);
        // Inputs are don't-care during the access.
        halted = 1'($urandom); data_rw = 1'($urandom); data_mem_write = 1'($urandom);
        alu_output = 8'($urandom); write_addr = 6'($urandom);
        cycles = noack ? TO : k;
        for (int i = 1; i <= cycles; i++) begin
          if (i > 1) begin
            @(negedge clk);
            check_eq("hold_req", mem_req, 1'b1);
            check_eq("hold_freeze", freeze, 1'b1);
            check_eq("hold_addr", mem_addr, exp_addr);
            check_eq("hold_we", mem_we, kind == 1);
            if (kind == 1) check_eq("hold_wdata", mem_wdata, alu);
          end
          mem_ack = (i == cycles) && !noack;
          mem_rdata = (mem_ack && kind == 2) ? dev_mem[mem_addr] : 8'($urandom);
        end
        if (kind == 2 && wa != 6'd0) exp_q.push_back({wa, noack ? 8'hFF : ref_mem[exp_addr]});
        if (kind == 1 && !noack) ref_mem[wa] = alu;
        if (noack) exp_err = 1'b1;
        @(negedge clk);
        drive_nop();
        check_eq("done_req", mem_req, 1'b0);
        check_eq("done_freeze", freeze, 1'b0);
        check_eq("done_wb_en", wb_en, kind == 2 && wa != 6'd0);
        check_eq("done_mem_err", mem_err, exp_err);
      end
    endcase
  endtask

  task automatic run_random(input int n);
    int         r, k;
    bit         noack;
    logic [5:0] wa;
    for (int i = 0; i < n; i++) begin
      r = $urandom_range(0, 9);
      wa = ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom);
      k = TO_EN ? $urandom_range(1, TO) : $urandom_range(1, 6);
      noack = TO_EN && ($urandom_range(0, 3) == 0);
      if (r < 4) run_instr(1'b0, 1'b0, 1'b0, 8'($urandom), wa, k, 1'b0);
      else if (r < 7) run_instr(1'b0, 1'b1, 1'b0, 8'($urandom), wa, k, noack);
      else run_instr(1'b0, 1'($urandom), 1'b1, 8'($urandom), wa, k, noack);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [7:0] v;
    for (int i = 0; i < 64; i++) begin
      v = 8'($urandom);
      ref_mem[i] = v;
      dev_mem[i] = v;
    end
    ref_mem[7] = 8'h21;
    dev_mem[7] = 8'h21;
    @(negedge clk);
    apply_reset();

    // Directed cases.
    run_instr(1'b0, 1'b0, 1'b0, 8'h5A, 6'd3, 1, 1'b0);
    run_instr(1'b0, 1'b1, 1'b0, 8'hC7, 6'd9, 3, 1'b0);
    run_instr(1'b0, 1'b1, 1'b1, 8'hAB, 6'h12, 2, 1'b0);
    run_instr(1'b0, 1'b1, 1'b0, 8'h12, 6'd4, 1, 1'b0);
    run_instr(1'b0, 1'b1, 1'b0, 8'h05, 6'd0, 2, 1'b0);
    run_instr(1'b0, 1'b0, 1'b0, 8'h77, 6'd0, 1, 1'b0);
    if (TO_EN) begin
      run_instr(1'b0, 1'b1, 1'b0, 8'h30, 6'd5, 1, 1'b1);
      run_instr(1'b0, 1'b1, 1'b0, 8'h31, 6'd6, TO, 1'b0);
    end

    run_random(300);

    // Reset two cycles into a load, then a stray ack.
    drive_nop();
    data_rw = 1'b1; alu_output = 8'h0B; write_addr = 6'd7;
    @(negedge clk);
    check_eq("rstmid_req", mem_req, 1'b1);
    drive_nop();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_all_zero("rstmid");
    halt_seen = 1'b0;
    exp_err = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mem_ack = 1'b1;
    mem_rdata = 8'h99;
    @(negedge clk);
    mem_ack = 1'b0;
    check_eq("stray_ack_wb_en", wb_en, 1'b0);
    check_eq("stray_ack_req", mem_req, 1'b0);
    check_eq("stray_ack_freeze", freeze, 1'b0);
    run_random(40);

    // Halt beats a simultaneous load; everything afterwards is ignored.
    run_instr(1'b1, 1'b1, 1'b0, 8'h44, 6'd8, 1, 1'b0);
    for (int i = 0; i < 8; i++)
      run_instr(1'b0, 1'($urandom), 1'($urandom), 8'($urandom), 6'($urandom_range(1, 63)), 1, 1'b0);
    drive_nop();
    apply_reset();
    run_random(40);

    drive_nop();
    repeat (3) @(negedge clk);
    check_eq("exp_q_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory stage of the mini-core pipeline, directly downstream of the EX pipeline register. It consumes the registered EX outputs and performs data-memory loads and stores over a req/ack handshake. It produces the register-file writeback for the WB stage. While a memory access is outstanding it stalls upstream via `freeze`, and it latches the core's halt condition.

## Interface
Parameters:
- `TO_CYCLES`, default 16: watchdog limit in cycles for one memory access. Used only with `MEM_TIMEOUT_EN`.

Ports:
- One clock; reset is asynchronous and active-low.
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: asynchronous active-low reset.
- `halted` input 1: halt marker from EX.
- `data_rw` input 1: load request from EX.
- `data_mem_write` input 1: store request from EX.
- `alu_output` input 8: ALU result from EX.
- `write_addr` input 6: destination register (load/ALU) or store address.
- `mem_req` output 1: memory request, held until ack.
- `mem_we` output 1: 1 = store, 0 = load.
- `mem_addr` output 6: memory address.
- `mem_wdata` output 8: store data.
- `mem_rdata` input 8: load data, valid when `mem_ack`=1.
- `mem_ack` input 1: single-cycle completion strobe.
- `freeze` output 1: stall to upstream stages.
- `wb_en` output 1: one-cycle writeback strobe.
- `wb_addr` output 6: writeback register.
- `wb_data` output 8: writeback data.
- `halted_out` output 1: sticky halt indication.
- `mem_err` output 1: sticky timeout error.

## Operation
- States: IDLE, ACCESS, HALT. Reset state is IDLE.
- All outputs reset to 0.
- Inputs are sampled only in IDLE. While in ACCESS or HALT, inputs are ignored.
- Decode in IDLE, in priority order:
  1. `halted`=1 → go to HALT; `halted_out`=1; no memory access; `wb_en`=0.
  2. `data_mem_write`=1 → store. `mem_addr`=`write_addr`, `mem_wdata`=`alu_output`, `mem_we`=1, `mem_req`=1; go to ACCESS. `data_rw` is ignored. No writeback.
  3. `data_rw`=1 → load. `mem_addr`=`alu_output[5:0]` (bits 7:6 ignored), `mem_we`=0, `mem_req`=1. Capture `write_addr` as the destination; go to ACCESS.
  4. Otherwise → ALU op. `wb_en`=1, `wb_addr`=`write_addr`, `wb_data`=`alu_output`.
- `write_addr`=0 suppresses `wb_en` for ALU ops and loads, because r0 is hardwired.
- ACCESS:
  - `mem_req`, `mem_we`, `mem_addr` and `mem_wdata` stay stable until `mem_ack` is sampled high.
  - On ack: `mem_req`=0 and go to IDLE.
  - For a load, also `wb_en`=1, `wb_addr`=destination, `wb_data`=`mem_rdata`.
  - `mem_ack` seen in IDLE or HALT is ignored.
- HALT is terminal; only `rst_n` leaves it.
- `freeze` = 1 whenever the state is ACCESS.
- `wb_en` is cleared on every cycle without a new writeback.
- `wb_addr` and `wb_data` hold their last values.

## Timing
- ALU op sampled at edge N: `wb_*` valid after N for exactly one cycle.
- Memory op sampled at edge N:
  - `mem_req` and `freeze` go high after N.
  - `mem_ack` is sampled high at edge N+k (k≥1).
  - After N+k: `mem_req`=0, `freeze`=0 and, for a load, `wb_en`=1.
  - The next instruction is sampled at N+k+1.
- Upstream holds its outputs while `freeze`=1. The first instruction after an access is therefore the one presented during ACCESS.
- Back-to-back accesses: `mem_req` is low for at least one cycle between transactions.
- Reset mid-access: `mem_req`, `freeze` and `wb_en` drop to 0 immediately and the state returns to IDLE. A later stray `mem_ack` is ignored.

## Configuration
- `MEM_TIMEOUT_EN` defined:
  - A counter runs while in ACCESS and clears on entry to ACCESS.
  - If `TO_CYCLES` edges elapse in ACCESS without `mem_ack`, the access aborts: `mem_req`=0, go to IDLE, `mem_err`=1 (sticky until reset).
  - A load that aborts writes back `wb_data`=8'hFF to its destination (subject to the r0 rule). A store that aborts writes nothing.
  - An ack arriving on the limit edge wins; no error is flagged.
- Not defined: no counter, ACCESS waits indefinitely, and `mem_err` is tied to 0.

## Test plan
- ALU op, `alu_output`=8'h5A, `write_addr`=6'd3 → one-cycle `wb_en`=1, `wb_addr`=3, `wb_data`=8'h5A; `freeze` never high.
- Load, `alu_output`=8'hC7, `write_addr`=9, ack after 3 cycles with `mem_rdata`=8'h21 → `mem_addr`=6'h07, `mem_we`=0, `freeze` high for 3 cycles, then `wb_en`=1 with `wb_addr`=9 and `wb_data`=8'h21.
- Store with both `data_mem_write`=1 and `data_rw`=1, `write_addr`=6'h12, `alu_output`=8'hAB → `mem_we`=1, `mem_addr`=6'h12, `mem_wdata`=8'hAB; `wb_en` stays 0.
- `halted`=1 together with `data_rw`=1 → `halted_out`=1, no `mem_req`; subsequent ALU ops produce no `wb_en` until `rst_n` is pulsed.
- `rst_n` asserted two cycles into a load → all outputs 0 immediately; an ack one cycle later causes no writeback.
- With `MEM_TIMEOUT_EN` and `TO_CYCLES`=4, load to r5 with no ack → after 4 cycles `mem_req`=0, `mem_err`=1, `wb_en`=1, `wb_addr`=5, `wb_data`=8'hFF.
